// File: rtl/sram_if_pkg.sv
// Shared definitions for the Sram read-port logic: port widths, read FSM encoding
// and the transfer-length width derivation.
package sram_if_pkg;

  localparam int SRAM_DATA_WIDTH = 8;
  localparam int SRAM_ADDR_WIDTH = 8;

  // One extra bit so a full sweep of the address space is expressible as a length.
  function automatic int len_width(input int addr_width);
    return addr_width + 1;
  endfunction

  localparam int SRAM_LEN_WIDTH = len_width(SRAM_ADDR_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/sram_rd_fifo2.sv
// Two-entry FIFO between the Sram read data and the output stream.
// head_r is the stream data register; tail_r holds the second word when full.
module sram_rd_fifo2 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [DATA_WIDTH-1:0] head_r;
  logic [DATA_WIDTH-1:0] tail_r;
  logic [1:0]            count_r;

  // Storage and occupancy update; the producer never pushes into a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= {DATA_WIDTH{1'b0}};
      tail_r  <= {DATA_WIDTH{1'b0}};
      count_r <= 2'd0;
    end else begin
      case (count_r)
        2'd0: begin
          if (push) begin
            head_r  <= push_data;
            count_r <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_r <= push_data;
          end else if (push) begin
            tail_r  <= push_data;
            count_r <= 2'd2;
          end else if (pop) begin
            count_r <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_r <= tail_r;
            if (push) begin
              tail_r <= push_data;
            end else begin
              count_r <= 2'd1;
            end
          end
        end
        default: begin
          count_r <= 2'd0;
        end
      endcase
    end
  end

  assign count     = count_r;
  assign out_valid = (count_r != 2'd0);
  assign out_data  = head_r;

endmodule

// File: rtl/sram_rd_streamer.sv
// Sram read-port master: sweeps an address range on start and streams the words out
// as valid/ready. Optional macro SRAM_RD_STRIDE_EN adds a programmable address stride.
module sram_rd_streamer
  import sram_if_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int LEN_WIDTH  = len_width(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
`ifdef SRAM_RD_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] stride,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  sram_csen,
  output logic                  sram_rd_en,
  output logic [ADDR_WIDTH-1:0] sram_rd_addr,
  input  logic [DATA_WIDTH-1:0] sram_rd_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);

  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  rd_state_e             state_r;
  rd_state_e             state_nxt_s;
  logic                  busy_r;
  logic                  done_r;
  logic [LEN_WIDTH-1:0]  rem_r;
  logic [ADDR_WIDTH-1:0] nxt_addr_r;
  logic [ADDR_WIDTH-1:0] last_addr_r;
  logic [ADDR_WIDTH-1:0] step_s;
  logic                  inflight_r;
  logic                  issue_s;
  logic                  accept_s;
  logic                  pop_s;
  logic                  fifo_valid_s;
  logic [1:0]            fifo_count_s;
  logic [2:0]            occ_s;
  logic                  drain_empty_s;

`ifdef SRAM_RD_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_r;

  // Stride is captured with the command so it cannot change mid-transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride_r <= {ADDR_WIDTH{1'b0}};
    end else if (accept_s) begin
      stride_r <= stride;
    end
  end

  assign step_s = stride_r;
`else
  assign step_s = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
`endif

  assign accept_s = (state_r == ST_IDLE) && start;
  assign pop_s    = fifo_valid_s && out_ready;

  // Words that will occupy the FIFO next cycle if nothing new is issued.
  assign occ_s = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};

  // Looks one cycle ahead so done follows the last handshake directly.
  assign drain_empty_s = !inflight_r &&
                         ((fifo_count_s == 2'd0) || ((fifo_count_s == 2'd1) && pop_s));

  // Next-state and read-issue decision.
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (length == LEN_ZERO) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_READ;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ: begin
        issue_s = (rem_r != LEN_ZERO) && (occ_s < 3'd2);
        if (issue_s && (rem_r == LEN_ONE)) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (drain_empty_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register with status flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // Command capture, address generation and in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r       <= LEN_ZERO;
      nxt_addr_r  <= {ADDR_WIDTH{1'b0}};
      last_addr_r <= {ADDR_WIDTH{1'b0}};
      inflight_r  <= 1'b0;
    end else begin
      inflight_r <= issue_s;
      if (accept_s) begin
        rem_r      <= length;
        nxt_addr_r <= base_addr;
      end else if (issue_s) begin
        rem_r       <= rem_r - LEN_ONE;
        nxt_addr_r  <= nxt_addr_r + step_s;
        last_addr_r <= nxt_addr_r;
      end
    end
  end

  sram_rd_fifo2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_r),
    .push_data (sram_rd_data),
    .pop       (pop_s),
    .count     (fifo_count_s),
    .out_valid (fifo_valid_s),
    .out_data  (out_data)
  );

  assign busy         = busy_r;
  assign done         = done_r;
  assign sram_csen    = busy_r;
  assign sram_rd_en   = issue_s;
  assign sram_rd_addr = issue_s ? nxt_addr_r : last_addr_r;
  assign out_valid    = fifo_valid_s;

endmodule

// File: tb/tb_sram_rd_streamer.sv
// Self-checking bench for sram_rd_streamer: directed cases plus randomized transfers
// checked against an address/data list computed from base, length and stride.
module tb_sram_rd_streamer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base_addr = 8'h00;
  logic [8:0] length = 9'd0;
`ifdef SRAM_RD_STRIDE_EN
  logic [7:0] stride = 8'h01;
`endif
  logic       busy, done, sram_csen, sram_rd_en, out_valid;
  logic [7:0] sram_rd_addr, out_data;
  logic [7:0] sram_rd_data = 8'h00;
  logic       out_ready = 1'b1;

  logic [7:0] mem [256];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_addr[$], exp_data[$], addr_q[$], data_q[$];
  int done_cnt, done_cyc, first_valid_cyc, last_pop_cyc, valid_cnt;
  int issued, popped, max_out;
  logic prev_v = 1'b0, prev_r = 1'b0;
  logic [7:0] prev_d = 8'h00;

  sram_rd_streamer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
`ifdef SRAM_RD_STRIDE_EN
    .stride       (stride),
`endif
    .busy         (busy),
    .done         (done),
    .sram_csen    (sram_csen),
    .sram_rd_en   (sram_rd_en),
    .sram_rd_addr (sram_rd_addr),
    .sram_rd_data (sram_rd_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready)
  );

  always #5 clk = ~clk;

  // Sram model: registered read, one cycle latency.
  always @(posedge clk) begin
    if (sram_csen && sram_rd_en) sram_rd_data <= mem[sram_rd_addr];
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    addr_q.delete();
    data_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    first_valid_cyc = -1;
    last_pop_cyc = -1;
    valid_cnt = 0;
    issued = 0;
    popped = 0;
    max_out = 0;
  endtask

  // Monitor sampled at the falling edge, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (issued - popped > max_out) max_out = issued - popped;
      if (sram_rd_en) begin
        addr_q.push_back(sram_rd_addr);
        issued++;
      end
      if (out_valid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        data_q.push_back(out_data);
        popped++;
        last_pop_cyc = cyc;
      end
      if (prev_v && !prev_r) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_d));
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_v = out_valid;
      prev_r = out_ready;
      prev_d = out_data;
    end else begin
      prev_v = 1'b0;
    end
  end

  // mode 0: ready always high; 1: 1010 pattern with a 5-cycle stall; 2: random ready.
  task automatic run_xfer(input logic [7:0] b, input int len, input logic [7:0] st,
                          input int mode, input bit poke);
    int  acc;
    bit  fin;
    logic [7:0] a;
    exp_addr.delete();
    exp_data.delete();
    for (int k = 0; k < len; k++) begin
      a = 8'(32'(b) + k * 32'(st));
      exp_addr.push_back(a);
      exp_data.push_back(mem[a]);
    end
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = b;
    length = 9'(len);
`ifdef SRAM_RD_STRIDE_EN
    stride = st;
`endif
    acc = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    fin = 1'b0;
    for (int i = 0; i < 600 && !fin; i++) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (i >= 6 && i <= 10) ? 1'b0 : ((i % 2) == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (poke && i == 2) begin
        start = 1'b1;
        base_addr = ~b;
        length = 9'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk); #1;
      if (done_cnt != 0) fin = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("word_count", 32'(data_q.size()), 32'(len));
    chk("issue_count", 32'(addr_q.size()), 32'(len));
    chk("max_buffered_le2", 32'(max_out <= 2), 32'd1);
    for (int k = 0; k < len; k++) begin
      chk("rd_addr", (k < addr_q.size()) ? 32'(addr_q[k]) : {32{1'bx}}, 32'(exp_addr[k]));
      chk("out_data", (k < data_q.size()) ? 32'(data_q[k]) : {32{1'bx}}, 32'(exp_data[k]));
    end
    if (len == 0) begin
      chk("done_cyc_len0", 32'(done_cyc), 32'(acc));
      chk("no_valid_len0", 32'(valid_cnt), 32'd0);
    end else begin
      chk("done_cyc", 32'(done_cyc), 32'(last_pop_cyc + 1));
      chk("first_valid_cyc", 32'(first_valid_cyc), 32'(acc + 2));
      if (mode == 0) chk("throughput", 32'(last_pop_cyc), 32'(acc + 1 + len));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_csen"}, 32'(sram_csen), 32'd0);
    chk({tag, "_rd_en"}, 32'(sram_rd_en), 32'd0);
    chk({tag, "_rd_addr"}, 32'(sram_rd_addr), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
  endtask

  initial begin
    logic [7:0] st;
    int len;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(posedge clk); #3;
    rst_n = 1'b1;

    run_xfer(8'h10, 4, 8'h01, 0, 1'b0);
    run_xfer(8'h55, 0, 8'h01, 0, 1'b0);
    run_xfer(8'hFE, 4, 8'h01, 0, 1'b0);
    run_xfer(8'h30, 8, 8'h01, 1, 1'b1);
`ifdef SRAM_RD_STRIDE_EN
    run_xfer(8'h00, 4, 8'd28, 0, 1'b1);
    run_xfer(8'h07, 5, 8'h00, 2, 1'b0);
`endif

    // Reset in the middle of an 8-word transfer, after the third word.
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = 8'h40;
    length = 9'd8;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (data_q.size() >= 3) break;
      @(posedge clk); #1;
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_no_done", 32'(done_cnt), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    run_xfer(8'h20, 2, 8'h01, 0, 1'b0);

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    run_xfer(8'($urandom), 256, 8'h01, 0, 1'b0);
    for (int t = 0; t < 8; t++) begin
`ifdef SRAM_RD_STRIDE_EN
      st = 8'($urandom);
`else
      st = 8'h01;
`endif
      len = int'($urandom_range(1, 24));
      run_xfer(8'($urandom), len, st, 2, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
